// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI flash read master.
package spi_pkg;
  localparam logic [7:0] SPI_CMD_READ = 8'h03;
  localparam logic [5:0] BYTE_BITS    = 6'd8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_CMD      = 3'd2,
    ST_DATA     = 3'd3,
    ST_STALL    = 3'd4,
    ST_CS_HOLD  = 3'd5,
    ST_CS_GAP   = 3'd6
  } state_e;
endpackage

// File: rtl/spi_clk_gen.sv
// Half-period counter producing SCLK and the ticks for the edges it is about to make.
// With i_hold set SCLK stays low and o_rise_tick just marks each ClkDiv-cycle interval.
module spi_clk_gen #(
  parameter int ClkDiv = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_en,
  input  logic i_hold,
  output logic o_sclk,
  output logic o_rise_tick,
  output logic o_fall_tick
);
  localparam int CntW = $clog2(ClkDiv + 1);

  logic [CntW-1:0] r_cnt;
  logic            r_sclk;
  logic            w_wrap;

  assign w_wrap      = i_en && (r_cnt == CntW'(ClkDiv - 1));
  assign o_rise_tick = w_wrap && !r_sclk;
  assign o_fall_tick = w_wrap && r_sclk;
  assign o_sclk      = r_sclk;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (!i_en) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + CntW'(1);
      if (w_wrap && !i_hold) r_sclk <= !r_sclk;
    end
  end
endmodule

// File: rtl/spi_flash_reader.sv
// SPI mode-0 read master: sends 0x03 + address, streams received bytes out on valid/ready,
// freezing SCLK low whenever the output slot is still occupied.
module spi_flash_reader
  import spi_pkg::*;
#(
  parameter int ClkDiv    = 2,
  parameter int AddrWidth = 24,
  parameter int LenWidth  = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [AddrWidth-1:0] req_addr,
  input  logic [LenWidth-1:0]  req_len,
  output logic                 spi_sclk,
  output logic                 spi_cs_n,
  output logic                 spi_mosi,
  input  logic                 spi_miso,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 done
);
  localparam int CmdBits = 8 + AddrWidth;

  state_e               r_state;
  logic [CmdBits-1:0]   r_cmd;
  logic [7:0]           r_rx;
  logic [LenWidth-1:0]  r_len;
  logic [5:0]           r_bcnt;
  logic [7:0]           r_out_data;
  logic                 r_cs_n, r_mosi, r_out_valid, r_done, r_req_ready;
  logic                 w_en, w_hold, w_rise, w_fall;
  logic                 w_accept, w_slot_free, w_last, w_byte_done, w_load;

  assign w_en        = (r_state != ST_IDLE) && (r_state != ST_STALL);
  assign w_hold      = (r_state == ST_CS_HOLD) || (r_state == ST_CS_GAP);
  assign w_accept    = req_valid && r_req_ready;
  assign w_slot_free = !r_out_valid || out_ready;
  assign w_last      = (r_len == LenWidth'(1));
  assign w_byte_done = (r_bcnt == BYTE_BITS);
  // A finished byte moves to the slot on its trailing fall edge, or when a stall clears.
  assign w_load      = w_slot_free && ((r_state == ST_STALL) ||
                                       (r_state == ST_DATA && w_fall && w_byte_done));

  spi_clk_gen #(.ClkDiv(ClkDiv)) u_clk_gen (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_en        (w_en),
    .i_hold      (w_hold),
    .o_sclk      (spi_sclk),
    .o_rise_tick (w_rise),
    .o_fall_tick (w_fall)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_cmd       <= '0;
      r_rx        <= '0;
      r_len       <= '0;
      r_bcnt      <= '0;
      r_out_data  <= '0;
      r_cs_n      <= 1'b1;
      r_mosi      <= 1'b0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      r_req_ready <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      if (w_load) begin
        r_out_data  <= r_rx;
        r_out_valid <= 1'b1;
        r_len       <= r_len - LenWidth'(1);
      end

      case (r_state)
        ST_IDLE: begin
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_cmd       <= {SPI_CMD_READ, req_addr};
            r_len       <= req_len;
            if (req_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= ST_CS_SETUP;
              r_cs_n  <= 1'b0;
              r_mosi  <= SPI_CMD_READ[7];
            end
          end
        end
        ST_CS_SETUP: if (w_rise) begin
          r_state <= ST_CMD;
          r_bcnt  <= 6'd1;
        end
        ST_CMD: begin
          if (w_rise) r_bcnt <= r_bcnt + 6'd1;
          if (w_fall) begin
            if (r_bcnt == 6'(CmdBits)) begin
              r_state <= ST_DATA;
              r_bcnt  <= '0;
              r_mosi  <= 1'b0;
            end else begin
              r_cmd  <= r_cmd << 1;
              r_mosi <= r_cmd[CmdBits-2];
            end
          end
        end
        ST_DATA: begin
          if (w_rise) begin
            r_rx   <= {r_rx[6:0], spi_miso};
            r_bcnt <= r_bcnt + 6'd1;
          end
          if (w_fall && w_byte_done) begin
            r_bcnt <= '0;
            if (!w_slot_free) r_state <= ST_STALL;
            else if (w_last)  r_state <= ST_CS_HOLD;
          end
        end
        ST_STALL: if (w_slot_free) r_state <= w_last ? ST_CS_HOLD : ST_DATA;
        ST_CS_HOLD: if (w_rise) begin
          r_state <= ST_CS_GAP;
          r_cs_n  <= 1'b1;
          r_done  <= 1'b1;
        end
        ST_CS_GAP: if (w_rise) begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign spi_cs_n  = r_cs_n;
  assign spi_mosi  = r_mosi;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign done      = r_done;
endmodule

// File: tb/tb_spi_flash_reader.sv
// Two readers (ClkDiv 2 and 1) against a behavioural 0x03-read flash; bytes go through a scoreboard.
module tb_spi_flash_reader;
  localparam int AW = 24;
  localparam int LW = 16;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [1:0]    req_valid, req_ready, sclk, cs_n, mosi, miso, out_valid, out_ready, done;
  logic [AW-1:0] req_addr [2];
  logic [LW-1:0] req_len  [2];
  logic [7:0]    out_data [2];
  logic [7:0]    mem [256];

  int          rises [2], csf [2], dones [2], gap [2];
  logic [31:0] cap   [2];
  time         pmin  [2], pmax [2];

  int         n_tests = 0, n_fail = 0;
  logic [7:0] sb_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    spi_flash_reader #(.ClkDiv(g == 0 ? 2 : 1), .AddrWidth(AW), .LenWidth(LW)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]),
      .req_addr(req_addr[g]), .req_len(req_len[g]),
      .spi_sclk(sclk[g]), .spi_cs_n(cs_n[g]), .spi_mosi(mosi[g]), .spi_miso(miso[g]),
      .out_data(out_data[g]), .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .done(done[g])
    );

    int          f_bits = 0, f_rises = 0, f_csf = 0, f_dones = 0, f_hi = 0, f_gap = 0;
    logic [31:0] f_cmd = '0;
    logic        f_miso = 1'b0, f_prev = 1'b0;
    time         f_tlast = 0, f_pmin = 0, f_pmax = 0;

    // Flash: shift in 32 cmd/addr bits on rises, drive mem[addr++] MSB first on falls.
    always @(negedge cs_n[g] or posedge sclk[g] or negedge sclk[g]) begin : b_flash
      logic [7:0] b;
      int d;
      if (sclk[g] == f_prev) begin
        f_bits = 0; f_csf++; f_tlast = 0; f_pmin = 0; f_pmax = 0;
      end else if (sclk[g] && !cs_n[g]) begin
        if (f_tlast != 0) begin
          if (f_pmin == 0 || $time - f_tlast < f_pmin) f_pmin = $time - f_tlast;
          if ($time - f_tlast > f_pmax) f_pmax = $time - f_tlast;
        end
        f_tlast = $time;
        f_rises++;
        if (f_bits < 32) f_cmd = {f_cmd[30:0], mosi[g]};
        f_bits++;
      end else if (!sclk[g] && !cs_n[g] && f_bits >= 32) begin
        d = f_bits - 32;
        b = mem[8'(f_cmd[7:0] + 8'(d / 8))];
        f_miso = b[3'(7 - d % 8)];
      end
      f_prev = sclk[g];
    end

    always @(negedge clk) begin
      if (done[g]) f_dones++;
      if (cs_n[g]) f_hi++;
      else begin
        if (f_hi != 0) f_gap = f_hi;
        f_hi = 0;
      end
    end

    assign miso[g]  = f_miso;
    assign rises[g] = f_rises;
    assign csf[g]   = f_csf;
    assign dones[g] = f_dones;
    assign gap[g]   = f_gap;
    assign cap[g]   = f_cmd;
    assign pmin[g]  = f_pmin;
    assign pmax[g]  = f_pmax;
  end

  // Scoreboard consumer: every accepted byte must match the oldest expected byte.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (reset_n && out_valid[g] && out_ready[g]) begin
        chk("rx_expected", 32'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) chk("rx_byte", out_data[g], sb_q.pop_front());
      end
    end
  end

  task automatic req(input int g, input logic [AW-1:0] a, input logic [LW-1:0] l, input bit push);
    int n = 0;
    while (!req_ready[g] && n < 2000) begin @(posedge clk); #1; n++; end
    chk("req_ready_wait", req_ready[g], 1);
    req_addr[g] = a; req_len[g] = l; req_valid[g] = 1'b1;
    @(posedge clk); #1;
    req_valid[g] = 1'b0;
    if (push) for (int i = 0; i < int'(l); i++) sb_q.push_back(mem[8'(a[7:0] + 8'(i))]);
  endtask

  task automatic wait_done(input int g, input int target);
    int n = 0;
    while (dones[g] < target && n < 3000) begin @(posedge clk); #1; n++; end
    chk("done_seen", 32'(dones[g] >= target), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int r0, c0, d0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
    mem[8'h45] = 8'hA5; mem[8'h46] = 8'h3C; mem[0] = 8'h5A;
    req_valid = '0; out_ready = 2'b11;
    for (int g = 0; g < 2; g++) begin req_addr[g] = '0; req_len[g] = '0; end
    reset_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_cs_n", cs_n, 2'b11);
    chk("rst_sclk", sclk, 2'b00);
    chk("rst_valid", out_valid, 2'b00);
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_done", done, 2'b00);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 1: basic two-byte read
    r0 = rises[0]; d0 = dones[0];
    req(0, 24'h012345, 16'd2, 1);
    wait_done(0, d0 + 1);
    repeat (10) @(posedge clk); #1;
    chk("t1_mosi", cap[0], 32'h03012345);
    chk("t1_rises", rises[0] - r0, 48);
    chk("t1_cs_high", cs_n[0], 1);
    chk("t1_one_done", dones[0] - d0, 1);
    chk("t1_pmin", 32'(pmin[0]), 40);
    chk("t1_pmax", 32'(pmax[0]), 40);
    chk("t1_drained", sb_q.size(), 0);

    // 2: back-pressure freezes SCLK
    d0 = dones[0];
    req(0, 24'h000010, 16'd4, 1);
    begin
      int n = 0;
      while (!out_valid[0] && n < 500) begin @(posedge clk); #1; n++; end
      chk("t2_first_byte", out_valid[0], 1);
    end
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    repeat (100) @(posedge clk); #1;
    r0 = rises[0];
    repeat (50) @(posedge clk); #1;
    chk("t2_frozen", rises[0] - r0, 0);
    chk("t2_sclk_low", sclk[0], 0);
    chk("t2_cs_low", cs_n[0], 0);
    chk("t2_held", out_valid[0], 1);
    out_ready[0] = 1'b1;
    wait_done(0, d0 + 1);
    repeat (10) @(posedge clk); #1;
    chk("t2_drained", sb_q.size(), 0);

    // 3: zero-length request
    c0 = csf[0]; r0 = rises[0]; d0 = dones[0];
    req(0, 24'h000100, 16'd0, 1);
    chk("t3_ready_low", req_ready[0], 0);
    chk("t3_done", done[0], 1);
    @(posedge clk); #1;
    chk("t3_done_1cyc", done[0], 0);
    chk("t3_ready_back", req_ready[0], 1);
    repeat (10) @(posedge clk); #1;
    chk("t3_no_cs", csf[0] - c0, 0);
    chk("t3_no_sclk", rises[0] - r0, 0);
    chk("t3_one_done", dones[0] - d0, 1);

    // 4: asynchronous reset mid-DATA
    out_ready[0] = 1'b0;
    d0 = dones[0];
    req(0, 24'h000020, 16'd3, 0);
    begin
      int n = 0;
      while (!out_valid[0] && n < 500) begin @(posedge clk); #1; n++; end
      chk("t4_loaded", out_valid[0], 1);
    end
    repeat (6) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t4_cs_n", cs_n[0], 1);
    chk("t4_sclk", sclk[0], 0);
    chk("t4_valid", out_valid[0], 0);
    chk("t4_ready", req_ready[0], 0);
    repeat (3) @(posedge clk); #1;
    reset_n = 1'b1;
    out_ready[0] = 1'b1;
    chk("t4_no_done", dones[0] - d0, 0);
    req(0, 24'h000000, 16'd1, 1);
    wait_done(0, d0 + 1);
    repeat (10) @(posedge clk); #1;
    chk("t4_drained", sb_q.size(), 0);

    // 5: back-to-back requests
    d0 = dones[0];
    req(0, 24'h000030, 16'd1, 1);
    chk("t5_busy", req_ready[0], 0);
    req(0, 24'h000031, 16'd1, 1);
    wait_done(0, d0 + 2);
    repeat (10) @(posedge clk); #1;
    chk("t5_gap", 32'(gap[0] >= 2), 1);
    chk("t5_drained", sb_q.size(), 0);

    // 6: fastest SCLK
    r0 = rises[1]; d0 = dones[1];
    req(1, 24'h000080, 16'd3, 1);
    wait_done(1, d0 + 1);
    repeat (10) @(posedge clk); #1;
    chk("t6_rises", rises[1] - r0, 56);
    chk("t6_pmin", 32'(pmin[1]), 20);
    chk("t6_pmax", 32'(pmax[1]), 20);
    chk("t6_mosi", cap[1], 32'h03000080);
    chk("t6_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
